mem_responder: RTL and testbench
================================

# mem_responder

Multi-cycle main-memory responder: the memory-side end of the pipeline CPU's memory request interface. It accepts single-word reads, single-word writes and 8-word burst reads (cache block fills) through a valid/ready request port, and returns read data after a fixed access latency on a response port. It sits behind the instruction/data memory paths (or a cache controller) in place of the single-cycle memories.

## Interface
- LATENCY, 4, cycles from request acceptance to first response beat (legal 1..15)
- BURST_LEN, 8, words per burst read (power of two, 2..16)
- WORDS_LOG2, 15, log2 of array depth in 16-bit words (byte address space 2^(WORDS_LOG2+1))
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_burst  in  1  1 = burst read (ignored when req_wr=1)
- req_addr  in  16  byte address; bit 0 ignored
- req_wdata  in  16  write data
- rsp_valid  out  1  read response beat valid
- rsp_data  out  16  read data
- rsp_addr  out  16  byte address of this beat (bit 0 = 0)
- rsp_last  out  1  final beat of the read (1 for single reads)
- busy  out  1  read in progress (~req_ready)

## Operation
- Handshake: request accepted on an edge where req_valid & req_ready. No request backpressure beyond req_ready; response has no ready, consumer must sink every beat.
- States: IDLE, WAIT, STREAM.
- IDLE: req_ready=1. Accepted write -> array word req_addr[WORDS_LOG2:1] written at that edge, stay IDLE. Accepted read -> latch word address, burst flag, load latency counter with LATENCY-1, go WAIT (LATENCY=1: go directly STREAM).
- WAIT: counter decrements each cycle; at 0 -> STREAM.
- STREAM: rsp_valid=1. Single read: one beat, rsp_last=1, -> IDLE. Burst: beat index i runs 0..BURST_LEN-1, address = block base (req_addr with low log2(BURST_LEN)+1 bits cleared) + 2i; rsp_last=1 on i=BURST_LEN-1, then -> IDLE.
- Address arithmetic: upper address bits above WORDS_LOG2 ignored (array wraps modulo depth); beat index never carries out of the block.
- Array contents captured at beat time (reads are not snapshotted at acceptance); no writes can occur during a read since req_ready=0.
- Reset: state -> IDLE, counters 0, rsp_valid=0, rsp_last=0, rsp_data=0, rsp_addr=0, req_ready=1 once rst deasserts, busy=0. In-flight read discarded, no partial beats after reset. Array contents are NOT cleared by reset.
- Array initial contents loaded by simulation initialisation file; not part of synthesised behaviour.

## Timing
- Read accepted at edge T: first beat valid in the cycle after edge T+LATENCY-1, i.e. LATENCY cycles after acceptance cycle.
- Burst: beats on consecutive cycles, last beat LATENCY+BURST_LEN-1 cycles after acceptance; req_ready high in the cycle after the last beat.
- Single read: req_ready high the cycle after its beat; back-to-back single reads therefore occupy LATENCY+1 cycles each.
- Writes: zero-wait; one accepted per cycle; read accepted in the cycle after a write to the same address returns the new data.
- Response outputs registered; req_ready/busy decoded from state register.

## Structure
- Package mem_pkg: state enum (IDLE, WAIT, STREAM), default LATENCY/BURST_LEN/WORDS_LOG2 constants.
- Sub-module mem_array: 2^WORDS_LOG2 x 16 array, synchronous write, asynchronous read, no reset.
- Top holds FSM, latency counter, beat counter, address registers, response registers.

## Test plan
- Write 0x1234 to 0x0010, then single read 0x0010 -> req_ready drops, rsp_valid one cycle exactly 4 cycles after acceptance, rsp_data=0x1234, rsp_addr=0x0010, rsp_last=1.
- Preload words 0x0020..0x002E with 0xA000+i; burst read req_addr=0x0026 -> 8 consecutive beats, addresses 0x0020..0x002E, data 0xA000..0xA007, rsp_last only on 8th, req_ready back the following cycle.
- req_valid held high with reads during WAIT/STREAM -> no second acceptance until IDLE; write with req_burst=1 -> single write, no response.
- Assert rst on 2nd burst beat -> rsp_valid=0 same cycle, all outputs reset values, later read of 0x0020 still returns 0xA000.
- Addresses 0x0011 and 0xFFFE with WORDS_LOG2=4 -> bit 0 ignored, 0xFFFE aliases word 15.
- LATENCY=1 build: single read response in cycle immediately after acceptance.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and default geometry for the memory responder.
package mem_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_BURST_LEN  = 8;
    localparam int DEF_WORDS_LOG2 = 15;
endpackage

// File: rtl/mem_array.sv
// mem_array: 16-bit word array with synchronous write and asynchronous read.
module mem_array #(
    parameter int WORDS_LOG2 = 15
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [WORDS_LOG2-1:0] waddr,
    input  logic [15:0]           wdata,
    input  logic [WORDS_LOG2-1:0] raddr,
    output logic [15:0]           rdata
);
    logic [15:0] mem [2**WORDS_LOG2];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle memory responder with single reads/writes and block-fill burst reads.
module mem_responder
    import mem_pkg::*;
#(
    parameter int LATENCY    = DEF_LATENCY,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int WORDS_LOG2 = DEF_WORDS_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_burst,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [15:0] rsp_addr,
    output logic        rsp_last,
    output logic        busy
);
    localparam int IW = $clog2(BURST_LEN);

    state_t        state;
    logic [3:0]    cnt;
    logic [IW-1:0] idx, beat_idx;
    logic [15:1]   base, src, beat_addr;
    logic          burst, src_burst, accept, emit;
    logic [15:0]   rdata;
    logic          unused_ok;

    assign unused_ok = req_addr[0];
    assign req_ready = state == IDLE;
    assign busy      = !req_ready;
    assign accept    = req_valid && req_ready;
    // In IDLE the beat source is the live request so LATENCY=1 can answer at the accept edge
    assign src       = req_ready ? req_addr[15:1] : base;
    assign src_burst = req_ready ? req_burst : burst;
    assign beat_idx  = state == STREAM ? idx + 1'b1 : '0;
    assign beat_addr = src_burst ? {src[15:IW+1], beat_idx} : src;
    assign emit      = (accept && !req_wr && LATENCY == 1) ||
                       (state == WAIT && cnt == 4'd1) ||
                       (state == STREAM && !rsp_last);

    mem_array #(.WORDS_LOG2(WORDS_LOG2)) u_array (
        .clk  (clk),
        .we   (accept && req_wr),
        .waddr(req_addr[WORDS_LOG2:1]),
        .wdata(req_wdata),
        .raddr(beat_addr[WORDS_LOG2:1]),
        .rdata(rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            base      <= '0;
            burst     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_data  <= '0;
            rsp_addr  <= '0;
        end else begin
            rsp_valid <= emit;
            rsp_last  <= emit && (!src_burst || beat_idx == IW'(BURST_LEN - 1));
            if (emit) begin
                rsp_data <= rdata;
                rsp_addr <= {beat_addr, 1'b0};
                idx      <= beat_idx;
            end
            unique case (state)
                IDLE: if (accept && !req_wr) begin
                    base  <= req_addr[15:1];
                    burst <= req_burst;
                    cnt   <= 4'(LATENCY - 1);
                    state <= LATENCY == 1 ? STREAM : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 4'd1) state <= STREAM;
                end
                STREAM: if (rsp_last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of the default build plus a LATENCY=1, 16-word build.
module tb_mem_responder;
    logic        clk = 1'b0, rst;
    logic        req_valid, req_ready, req_wr, req_burst, rsp_valid, rsp_last, busy;
    logic [15:0] req_addr, req_wdata, rsp_data, rsp_addr;
    logic        v1, r1_ready, w1, b1, r1_valid, r1_last, r1_busy;
    logic [15:0] a1, d1, r1_data, r1_addr;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_last(rsp_last), .busy(busy)
    );

    mem_responder #(.LATENCY(1), .WORDS_LOG2(4)) dut1 (
        .clk(clk), .rst(rst), .req_valid(v1), .req_ready(r1_ready), .req_wr(w1),
        .req_burst(b1), .req_addr(a1), .req_wdata(d1), .rsp_valid(r1_valid),
        .rsp_data(r1_data), .rsp_addr(r1_addr), .rsp_last(r1_last), .busy(r1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
        req_valid = 1'b1; req_wr = 1'b1; req_burst = b; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_wr = 1'b0; req_burst = 1'b0;
    endtask

    // Issue a read, check first-beat latency, then n beats of address/data/last.
    task automatic rd(input logic [15:0] a, input logic b, input int n,
                      input logic [15:0] a0, input logic [15:0] d0);
        int k;
        chk("rd_ready", req_ready, 1);
        req_valid = 1'b1; req_wr = 1'b0; req_burst = b; req_addr = a;
        @(negedge clk);
        req_valid = 1'b0; req_burst = 1'b0;
        chk("rd_busy", busy, 1);
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rd_latency", k, 4);
        for (int i = 0; i < n; i++) begin
            chk("beat_valid", rsp_valid, 1);
            chk("beat_addr", rsp_addr, a0 + 16'(2 * i));
            chk("beat_data", rsp_data, d0 + 16'(i));
            chk("beat_last", rsp_last, i == n - 1);
            @(negedge clk);
        end
        chk("end_valid", rsp_valid, 0);
        chk("end_ready", req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 0; req_wr = 0; req_burst = 0; req_addr = 0; req_wdata = 0;
        v1 = 0; w1 = 0; b1 = 0; a1 = 0; d1 = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        wr(16'h0010, 16'h1234, 1'b0);
        rd(16'h0010, 1'b0, 1, 16'h0010, 16'h1234);

        for (int i = 0; i < 8; i++) wr(16'h0020 + 16'(2 * i), 16'hA000 + 16'(i), 1'b0);
        rd(16'h0026, 1'b1, 8, 16'h0020, 16'hA000);

        // req_valid held through the whole read must not start a second one
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("hold_ready", req_ready, 0);
            chk("hold_valid", rsp_valid, k == 4);
        end
        chk("hold_data", rsp_data, 16'h1234);
        @(negedge clk);
        chk("hold_idle", req_ready, 1);
        chk("hold_novalid", rsp_valid, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("hold_notbusy", busy, 0);

        wr(16'h0040, 16'h5555, 1'b1);
        chk("wburst_norsp", rsp_valid, 0);
        chk("wburst_ready", req_ready, 1);
        rd(16'h0040, 1'b0, 1, 16'h0040, 16'h5555);

        wr(16'h0030, 16'hBEEF, 1'b0);
        rd(16'h0030, 1'b0, 1, 16'h0030, 16'hBEEF);

        wr(16'h0011, 16'h1111, 1'b0);
        rd(16'h0011, 1'b0, 1, 16'h0010, 16'h1111);

        // Reset during the second burst beat
        req_valid = 1'b1; req_burst = 1'b1; req_addr = 16'h002A;
        @(negedge clk);
        req_valid = 1'b0; req_burst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rb_beat1_addr", rsp_addr, 16'h0022);
        chk("rb_beat1_valid", rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("rb_valid", rsp_valid, 0);
        chk("rb_last", rsp_last, 0);
        chk("rb_data", rsp_data, 0);
        chk("rb_addr", rsp_addr, 0);
        chk("rb_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rb_after_valid", rsp_valid, 0);
        rd(16'h0020, 1'b0, 1, 16'h0020, 16'hA000);

        // LATENCY=1, 16-word build: 0xFFFE aliases word 15
        v1 = 1'b1; w1 = 1'b1; a1 = 16'hFFFE; d1 = 16'h7777;
        @(negedge clk);
        w1 = 1'b0; a1 = 16'h001E;
        @(negedge clk);
        v1 = 1'b0;
        chk("l1_valid", r1_valid, 1);
        chk("l1_data", r1_data, 16'h7777);
        chk("l1_addr", r1_addr, 16'h001E);
        chk("l1_last", r1_last, 1);
        chk("l1_busy", r1_busy, 1);
        @(negedge clk);
        chk("l1_end_valid", r1_valid, 0);
        chk("l1_end_ready", r1_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
